throw_sprite_engine: RTL
========================

Name: throw_sprite_engine

Overview:
- Downstream consumer of the 32x32, 2-bit-per-pixel thrown-object sprite RAM.
- Owns the thrown object's position and flight state machine, updated once per video frame.
- For each scanned pixel, it generates the RAM read address, absorbs the RAM's 1-cycle registered read latency, and maps the 2-bit colour index to 12-bit RGB.
- Outputs feed the frame's pixel mux alongside the player and background layers.

Parameters:
- ADDR_WIDTH, 10, sprite RAM address width (32x32 sprite, 5-bit row and 5-bit column).
- H_MAX, 640, visible width in pixels.
- GROUND_Y, 448, first scan line below the landing surface.
- GRAVITY, 1, vy increment per frame.
- VY_MAX, 15, positive (downward) vy saturation value.
- HOLD_FRAMES, 30, frames the landed sprite stays visible.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  11  current pixel column from the sync generator
- y  in  11  current pixel row
- frame_tick  in  1  1-cycle pulse at frame start
- throw_req  in  1  launch request pulse
- throw_x0  in  11  launch column (sprite top-left)
- throw_y0  in  11  launch row
- throw_vx  in  6  signed launch horizontal velocity
- throw_vy  in  7  signed launch vertical velocity (negative = up)
- ram_addr_r  out  ADDR_WIDTH  sprite RAM read address
- ram_dout  in  2  sprite RAM data, valid 1 cycle after ram_addr_r
- sprite_rgb  out  12  pixel colour
- sprite_en  out  1  sprite pixel is opaque and valid
- busy  out  1  high in FLIGHT or LANDED

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state=IDLE; pos_x, pos_y, vx, vy, hold_cnt = 0; sprite_rgb=0; sprite_en=0; busy=0; pipeline hit flag=0. Reset mid-flight aborts immediately, with no landing or hold phase.
- FSM states IDLE, FLIGHT, LANDED; busy = (state != IDLE).
- IDLE, throw_req=1: load pos_x<=throw_x0, pos_y<=throw_y0, vx<=throw_vx, vy<=throw_vy; go to FLIGHT.
  - throw_req ignored outside IDLE.
  - throw_req and frame_tick in the same cycle: the load wins; no motion that frame.
- FLIGHT, on frame_tick:
  - Next-state maths in 13-bit signed: nx = pos_x + vx, ny = pos_y + vy.
  - vy <= min(vy + GRAVITY, VY_MAX).
  - nx < 0: pos_x <= 0, vx <= -vx.
  - nx > H_MAX-32: pos_x <= H_MAX-32, vx <= -vx.
  - ny < 0: pos_y <= 0, vy <= 0.
  - ny >= GROUND_Y-32: pos_y <= GROUND_Y-32, vx <= 0, vy <= 0, hold_cnt <= HOLD_FRAMES-1, state <= LANDED.
  - Otherwise pos_x <= nx, pos_y <= ny.
- LANDED, on frame_tick: if hold_cnt == 0, go to IDLE; otherwise decrement hold_cnt.
- Position registers change only on frame_tick, or on the IDLE load.
- Pixel path, stage 0 (combinational):
  - hit0 = busy & (x - pos_x) in [0,31] & (y - pos_y) in [0,31], computed unsigned 11-bit with bounds checked.
  - ram_addr_r = {row[4:0], col[4:0]}, where row = y - pos_y and col = x - pos_x.
  - ram_addr_r is driven even when hit0=0; its value is then don't-care.
- Pixel path, stage 1: register hit0 to hit1, aligned with ram_dout.
- Pixel path, stage 2 (registered outputs):
  - sprite_en <= hit1 & (ram_dout != 0).
  - sprite_rgb <= palette(ram_dout), or 0 when !hit1.
  - Palette: 0 = transparent (rgb 000), 1 = 12'hFFF, 2 = 12'hF80, 3 = 12'h420.
- Latency: x/y to sprite_rgb/sprite_en is exactly 2 clocks. The upstream sync generator delays its own layers to match.
- Sprite touching the right edge (pos_x = H_MAX-32): columns 608..639 inclusive are rendered.
- A pixel with x >= H_MAX is never a hit.

Optional Feature:
- THROW_MIRROR_EN defined: when vx < 0, the column index is mirrored, col' = 31 - col, so the sprite faces its direction of travel. Mirroring is re-evaluated each frame, so after a bounce the sprite flips on the same frame_tick that negates vx.
- Not defined: col is always used unmirrored; no extra logic.

Test Plan:
- Reset mid-FLIGHT at pos (300,200) -> next cycle busy=0, sprite_en=0, sprite_rgb=0; the following throw_req loads cleanly.
- throw_req with x0=100, y0=100, vx=3, vy=-4, then 3 frame_ticks -> pos (103,96), (106,93), (109,91); vy=-1 after tick 3.
- Pixel scan at (100,100) with ram_dout=2 returned the next cycle -> ram_addr_r=0; sprite_en=1, sprite_rgb=12'hF80 two clocks after x/y; (99,100) -> sprite_en=0; ram_dout=0 -> sprite_en=0.
- Launch at x0=606 with vx=5 -> after 1 tick pos_x=608, vx=-5; with THROW_MIRROR_EN, col 0 reads address col 31.
- Fall with vy reaching 15 near GROUND_Y -> pos_y clamps to 416, state LANDED; exactly 30 further frame_ticks return to IDLE and busy drops.
- throw_req during FLIGHT -> ignored, trajectory unchanged; throw_req coincident with frame_tick in IDLE -> loaded position held through that tick.

Source files
------------

// File: rtl/throw_sprite_engine.sv
// rtl/throw_sprite_engine.sv - thrown-object flight FSM and 2-clock sprite pixel pipeline
// Optional build macro THROW_MIRROR_EN: mirror sprite columns while travelling left.
module throw_sprite_engine #(
    parameter int ADDR_WIDTH  = 10,
    parameter int H_MAX       = 640,
    parameter int GROUND_Y    = 448,
    parameter int GRAVITY     = 1,
    parameter int VY_MAX      = 15,
    parameter int HOLD_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  frame_tick,
    input  logic                  throw_req,
    input  logic [10:0]           throw_x0,
    input  logic [10:0]           throw_y0,
    input  logic [5:0]            throw_vx,
    input  logic [6:0]            throw_vy,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [1:0]            ram_dout,
    output logic [11:0]           sprite_rgb,
    output logic                  sprite_en,
    output logic                  busy
);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic signed [12:0] X_LIM  = 13'(H_MAX - 32);
    localparam logic signed [12:0] Y_LIM  = 13'(GROUND_Y - 32);
    localparam logic signed [7:0]  VY_LIM = 8'(VY_MAX);
    localparam logic signed [7:0]  GRAV   = 8'(GRAVITY);

    typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;

    state_t             state_q;
    logic [10:0]        pos_x_q, pos_y_q;
    logic signed [5:0]  vx_q;
    logic signed [6:0]  vy_q;
    logic [HW-1:0]      hold_cnt_q;
    logic               hit1_q, sprite_en_q;
    logic [11:0]        sprite_rgb_q;

    logic signed [12:0] nx_d, ny_d;
    logic signed [7:0]  vy_inc_d;
    logic signed [6:0]  vy_grav_d;

    assign nx_d      = $signed({2'b00, pos_x_q}) + 13'(vx_q);
    assign ny_d      = $signed({2'b00, pos_y_q}) + 13'(vy_q);
    assign vy_inc_d  = 8'(vy_q) + GRAV;
    assign vy_grav_d = (vy_inc_d > VY_LIM) ? 7'(VY_MAX) : vy_inc_d[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            vx_q       <= '0;
            vy_q       <= '0;
            hold_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (throw_req) begin
                    pos_x_q <= throw_x0;
                    pos_y_q <= throw_y0;
                    vx_q    <= throw_vx;
                    vy_q    <= throw_vy;
                    state_q <= FLIGHT;
                end
                FLIGHT: if (frame_tick) begin
                    vy_q <= vy_grav_d;
                    if (nx_d < 0) begin
                        pos_x_q <= '0;
                        vx_q    <= -vx_q;
                    end else if (nx_d > X_LIM) begin
                        pos_x_q <= X_LIM[10:0];
                        vx_q    <= -vx_q;
                    end else begin
                        pos_x_q <= nx_d[10:0];
                    end
                    // Landing overrides any horizontal bounce on the same frame.
                    if (ny_d < 0) begin
                        pos_y_q <= '0;
                        vy_q    <= '0;
                    end else if (ny_d >= Y_LIM) begin
                        pos_y_q    <= Y_LIM[10:0];
                        vx_q       <= '0;
                        vy_q       <= '0;
                        hold_cnt_q <= HW'(HOLD_FRAMES - 1);
                        state_q    <= LANDED;
                    end else begin
                        pos_y_q <= ny_d[10:0];
                    end
                end
                LANDED: if (frame_tick) begin
                    if (hold_cnt_q == '0) state_q <= IDLE;
                    else                  hold_cnt_q <= hold_cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [10:0] dx, dy;
    logic [4:0]  col;
    logic        hit0;

    assign busy = (state_q != IDLE);
    assign dx   = x - pos_x_q;
    assign dy   = y - pos_y_q;
    assign hit0 = busy && (dx[10:5] == '0) && (dy[10:5] == '0) && (x < 11'(H_MAX));
`ifdef THROW_MIRROR_EN
    assign col  = vx_q[5] ? ~dx[4:0] : dx[4:0];
`else
    assign col  = dx[4:0];
`endif
    assign ram_addr_r = ADDR_WIDTH'({dy[4:0], col});

    // hit1 lines up with ram_dout, which the RAM returns one clock after the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit1_q       <= 1'b0;
            sprite_en_q  <= 1'b0;
            sprite_rgb_q <= '0;
        end else begin
            hit1_q      <= hit0;
            sprite_en_q <= hit1_q && (ram_dout != 2'd0);
            if (!hit1_q) sprite_rgb_q <= '0;
            else begin
                case (ram_dout)
                    2'd1:    sprite_rgb_q <= 12'hFFF;
                    2'd2:    sprite_rgb_q <= 12'hF80;
                    2'd3:    sprite_rgb_q <= 12'h420;
                    default: sprite_rgb_q <= 12'h000;
                endcase
            end
        end
    end

    assign sprite_en  = sprite_en_q;
    assign sprite_rgb = sprite_rgb_q;
endmodule
